// File: rtl/complex_add_if.sv
// ----------------------------------------------------------------------------
// complex_add_if
// Handshake bundle for the complex_add block.
//   operands_i  [3:0][63:0]  {b2,a2,b1,a1}: binary64 operands (re1, im1, re2, im2)
//   sub                      0 = add, 1 = subtract
//   in_valid_i / in_ready_o  input handshake
//   flush_i                  synchronous discard of a held result
//   result_o    [1:0][63:0]  [0] = real part, [1] = imaginary part
//   out_valid_o / out_ready_i output handshake
//   busy_o                   a result is held and not yet consumed
// Modports: slave = the adder block, master = the producer/consumer side.
// ----------------------------------------------------------------------------
interface complex_add_if;
    logic [3:0][63:0] operands_i;
    logic             sub;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             flush_i;
    logic [1:0][63:0] result_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             busy_o;

    modport slave (
        input  operands_i, sub, in_valid_i, flush_i, out_ready_i,
        output in_ready_o, result_o, out_valid_o, busy_o
    );

    modport master (
        output operands_i, sub, in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, result_o, out_valid_o, busy_o
    );
endinterface

// File: rtl/complex_add.sv
// ----------------------------------------------------------------------------
// complex_add
// Complex add/subtract of two binary64 complex numbers with one cycle of
// latency and a single-entry output register (valid/ready on both sides).
// Two identical binary64 adders run in parallel: real lane (a1 +/- a2) and
// imaginary lane (b1 +/- b2). Subtraction flips the sign of the second operand.
// Subnormal inputs read as signed zero; subnormal results flush to zero.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   io_bus  complex_add_if.slave handshake bundle
// ----------------------------------------------------------------------------
module complex_add (
    input  logic          clk_i,
    input  logic          rst_ni,
    complex_add_if.slave  io_bus
);

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    // Leading-zero count of a 56-bit value (56 when the value is zero).
    function automatic logic [5:0] lzc56(input logic [55:0] v);
        logic [5:0] n;
        n = 6'd56;
        for (int i = 0; i < 56; i++) begin
            if (v[i]) n = 6'(55 - i);
        end
        return n;
    endfunction

    // One binary64 adder lane: a + b, round to nearest even, flush-to-zero.
    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        logic        sa, sb, sl, ss;
        logic [10:0] ea, eb, el, es, d;
        logic [51:0] fa, fb, fl, fs;
        logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        logic [55:0] ml, ms, ms_sh, norm;
        logic        lost, rnd;
        logic [56:0] sum;
        logic [5:0]  lz;
        logic [12:0] e;
        logic [53:0] mant;
        logic [63:0] res;

        // NOTE: every local gets a value before any branch reads or skips it,
        // so the enclosing always_comb cannot infer a latch.
        sa = a[63]; ea = a[62:52]; fa = a[51:0];
        sb = b[63]; eb = b[62:52]; fb = b[51:0];
        sl = 1'b0; ss = 1'b0; el = '0; es = '0; fl = '0; fs = '0; d = '0;
        ml = '0; ms = '0; ms_sh = '0; norm = '0; lost = 1'b0; rnd = 1'b0;
        sum = '0; lz = '0; e = '0; mant = '0; res = '0;

        nan_a  = (ea == 11'h7FF) && (fa != '0);
        nan_b  = (eb == 11'h7FF) && (fb != '0);
        inf_a  = (ea == 11'h7FF) && (fa == '0);
        inf_b  = (eb == 11'h7FF) && (fb == '0);
        zero_a = (ea == 11'h000);    // subnormals read as signed zero
        zero_b = (eb == 11'h000);

        if (nan_a || nan_b) begin
            res = QNAN;
        end else if (inf_a && inf_b) begin
            res = (sa != sb) ? QNAN : a;
        end else if (inf_a) begin
            res = a;
        end else if (inf_b) begin
            res = b;
        end else if (zero_a && zero_b) begin
            // Only (-0)+(-0) keeps the negative sign.
            res = {sa & sb, 63'b0};
        end else if (zero_a) begin
            res = b;
        end else if (zero_b) begin
            res = a;
        end else begin
            // Larger magnitude first so the mantissa difference is never negative.
            if ({ea, fa} >= {eb, fb}) begin
                sl = sa; el = ea; fl = fa; ss = sb; es = eb; fs = fb;
            end else begin
                sl = sb; el = eb; fl = fb; ss = sa; es = ea; fs = fa;
            end
            // Hidden bit, 52 fraction bits, then guard/round/sticky.
            ml = {1'b1, fl, 3'b000};
            ms = {1'b1, fs, 3'b000};
            d  = el - es;
            if (d >= 11'd56) begin
                ms_sh = 56'd1;
            end else begin
                ms_sh    = ms >> d;
                lost     = |(ms & ((56'd1 << d) - 56'd1));
                ms_sh[0] = ms_sh[0] | lost;
            end

            sum = (sl != ss) ? ({1'b0, ml} - {1'b0, ms_sh})
                             : ({1'b0, ml} + {1'b0, ms_sh});

            if (sum == '0) begin
                res = '0;    // exact cancellation gives +0
            end else begin
                if (sum[56]) begin
                    // Carry out: shift right one, folding the lost bit into sticky.
                    norm = {sum[56:2], sum[1] | sum[0]};
                    e    = {2'b00, el} + 13'd1;
                end else begin
                    lz   = lzc56(sum[55:0]);
                    norm = sum[55:0] << lz;
                    e    = {2'b00, el} - {7'b0, lz};
                end

                if (e[12] || (e == 13'd0)) begin
                    res = {sl, 63'b0};
                end else begin
                    // Mantissa in norm[55:3], guard in norm[2], sticky from norm[1:0].
                    rnd  = norm[2] & (norm[3] | norm[1] | norm[0]);
                    mant = {1'b0, norm[55:3]} + {53'b0, rnd};
                    if (mant[53]) begin
                        mant = mant >> 1;
                        e    = e + 13'd1;
                    end
                    if (e >= 13'd2047) res = {sl, 11'h7FF, 52'b0};
                    else               res = {sl, e[10:0], mant[51:0]};
                end
            end
        end
        return res;
    endfunction

    logic [1:0][63:0] r_result;
    logic             r_out_valid;
    logic [1:0][63:0] w_result;
    logic             w_accept;

    always_comb begin
        w_result[0] = fp_add(io_bus.operands_i[0],
                             {io_bus.operands_i[2][63] ^ io_bus.sub, io_bus.operands_i[2][62:0]});
        w_result[1] = fp_add(io_bus.operands_i[1],
                             {io_bus.operands_i[3][63] ^ io_bus.sub, io_bus.operands_i[3][62:0]});
    end

    assign io_bus.in_ready_o  = !r_out_valid || io_bus.out_ready_i;
    assign w_accept           = io_bus.in_valid_i && io_bus.in_ready_o && !io_bus.flush_i;
    assign io_bus.result_o    = r_result;
    assign io_bus.out_valid_o = r_out_valid;
    assign io_bus.busy_o      = r_out_valid;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (io_bus.flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
        end else if (r_out_valid && io_bus.out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_complex_add.sv
// ----------------------------------------------------------------------------
// tb_complex_add
// Directed and randomized checks of complex_add. The reference lane model uses
// the simulator's own binary64 arithmetic (round to nearest even) and then
// applies the block's zero/NaN conventions; a transaction-level scoreboard
// tracks the single held result.
// ----------------------------------------------------------------------------
module tb_complex_add;

    localparam logic [63:0] ONE  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] TWO  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] HALF = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic clk_i;
    logic rst_ni;
    int   n_checks;
    int   n_errors;

    logic [63:0] specials [8] = '{
        64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000,
        64'h7FF8_0000_0000_0001, 64'h0000_0000_0000_0000,
        64'h8000_0000_0000_0000, 64'h7FEF_FFFF_FFFF_FFFF,
        64'h000F_FFFF_FFFF_FFFF, 64'h3FF0_0000_0000_0000
    };

    complex_add_if bus ();

    complex_add dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .io_bus (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != '0);
    endfunction

    // Reference lane: IEEE binary64 add/sub, inputs and outputs flushed.
    function automatic logic [63:0] ref_lane(input logic [63:0] x, input logic [63:0] y,
                                             input logic sub);
        logic [63:0] xf, yf, rb;
        real         r;
        xf = (x[62:52] == 11'h0) ? {x[63], 63'b0} : x;
        yf = (y[62:52] == 11'h0) ? {y[63], 63'b0} : y;
        if (is_nan(xf) || is_nan(yf)) return QNAN;
        r  = sub ? ($bitstoreal(xf) - $bitstoreal(yf)) : ($bitstoreal(xf) + $bitstoreal(yf));
        rb = $realtobits(r);
        if (is_nan(rb)) return QNAN;
        if (rb[62:52] == 11'h0) return {rb[63], 63'b0};
        return rb;
    endfunction

    function automatic logic [127:0] ref_op(input logic [3:0][63:0] ops, input logic sub);
        return {ref_lane(ops[1], ops[3], sub), ref_lane(ops[0], ops[2], sub)};
    endfunction

    task automatic rand_pair(output logic [63:0] x, output logic [63:0] y);
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       y[62:52] = x[62:52];
            1:       y[62:52] = x[62:52] - 11'($urandom_range(0, 60));
            2:       y = specials[$urandom_range(0, 7)];
            3:       x = specials[$urandom_range(0, 7)];
            4:       y = x;
            5:       y = {~x[63], x[62:0]};
            default: ;
        endcase
    endtask

    // Drive one operation with the output always ready, then check its result.
    task automatic issue(input string tag, input logic [3:0][63:0] ops, input logic sub,
                         input logic [127:0] exp);
        bus.operands_i  = ops;
        bus.sub         = sub;
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        step();
        bus.in_valid_i  = 1'b0;
        check(tag, 128'(bus.result_o), exp);
        check_bit({tag, "_valid"}, bus.out_valid_o, 1'b1);
    endtask

    logic [3:0][63:0] ops_x, ops_y;
    logic [127:0]     held;
    logic             exp_valid;
    logic [127:0]     exp_res;

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_ni          = 1'b0;
        bus.operands_i  = '0;
        bus.sub         = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;

        // Reset state
        #13;
        check_bit("rst_valid", bus.out_valid_o, 1'b0);
        check_bit("rst_busy", bus.busy_o, 1'b0);
        check_bit("rst_ready", bus.in_ready_o, 1'b1);
        check("rst_result", 128'(bus.result_o), '0);
        rst_ni = 1'b1;
        step();
        check_bit("idle_valid", bus.out_valid_o, 1'b0);

        // Directed function checks, issued back to back
        issue("basic_add", {HALF, TWO, TWO, ONE}, 1'b0, {64'h4004_0000_0000_0000, 64'h4008_0000_0000_0000});
        check_bit("basic_busy", bus.busy_o, 1'b1);
        issue("cancel", {TWO, ONE, TWO, ONE}, 1'b1, '0);
        issue("tie_even", {64'h3CA0_0000_0000_0000, 64'h3CA0_0000_0000_0000, ONE, ONE}, 1'b0, {ONE, ONE});
        issue("tie_odd", {64'h3CA0_0000_0000_0000, 64'h3CA0_0000_0000_0000,
                          64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001}, 1'b0,
              {64'h3FF0_0000_0000_0002, 64'h3FF0_0000_0000_0002});
        issue("special", {64'h7FEF_FFFF_FFFF_FFFF, 64'hFFF0_0000_0000_0000,
                          64'h7FEF_FFFF_FFFF_FFFF, 64'h7FF0_0000_0000_0000}, 1'b0,
              {64'h7FF0_0000_0000_0000, QNAN});
        issue("sub_swap", {64'h4008_0000_0000_0000, HALF, ONE, 64'h4008_0000_0000_0000}, 1'b1,
              {64'hC000_0000_0000_0000, 64'h4004_0000_0000_0000});
        issue("subn_negz", {64'h8000_0000_0000_0000, ONE, 64'h8000_0000_0000_0000, 64'h000F_FFFF_FFFF_FFFF},
              1'b0, {64'h8000_0000_0000_0000, ONE});
        issue("inf_nan", {ONE, 64'h4014_0000_0000_0000, 64'h7FF0_0000_0000_0001, 64'hFFF0_0000_0000_0000},
              1'b0, {QNAN, 64'hFFF0_0000_0000_0000});
        step();
        check_bit("drain_valid", bus.out_valid_o, 1'b0);

        // Backpressure: result held, no acceptance while stalled
        ops_x = {TWO, TWO, ONE, ONE};
        issue("bp_first", ops_x, 1'b0, ref_op(ops_x, 1'b0));
        held = 128'(bus.result_o);
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.operands_i  = {ONE, ONE, ONE, ONE};
        for (int i = 0; i < 3; i++) begin
            #1;
            check_bit("bp_ready", bus.in_ready_o, 1'b0);
            step();
            check("bp_hold", 128'(bus.result_o), held);
            check_bit("bp_valid", bus.out_valid_o, 1'b1);
            check_bit("bp_busy", bus.busy_o, 1'b1);
        end
        ops_y = {HALF, ONE, TWO, HALF};
        bus.operands_i  = ops_y;
        bus.out_ready_i = 1'b1;
        #1;
        check_bit("bp_release_ready", bus.in_ready_o, 1'b1);
        step();
        bus.in_valid_i = 1'b0;
        check("bp_new", 128'(bus.result_o), ref_op(ops_y, 1'b0));
        check_bit("bp_new_valid", bus.out_valid_o, 1'b1);
        step();
        check_bit("bp_consumed", bus.out_valid_o, 1'b0);

        // Flush while held and stalled
        issue("fl_first", ops_x, 1'b0, ref_op(ops_x, 1'b0));
        bus.out_ready_i = 1'b0;
        bus.flush_i     = 1'b1;
        step();
        bus.flush_i = 1'b0;
        check_bit("fl_valid", bus.out_valid_o, 1'b0);
        check_bit("fl_busy", bus.busy_o, 1'b0);

        // Flush blocks an acceptance that would otherwise happen
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.operands_i  = ops_y;
        bus.flush_i     = 1'b1;
        step();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        check_bit("fl_block", bus.out_valid_o, 1'b0);

        // Asynchronous reset while a result is held
        issue("rs_first", ops_x, 1'b0, ref_op(ops_x, 1'b0));
        bus.out_ready_i = 1'b0;
        #3;
        rst_ni = 1'b0;
        #1;
        check_bit("rs_valid", bus.out_valid_o, 1'b0);
        check_bit("rs_busy", bus.busy_o, 1'b0);
        check_bit("rs_ready", bus.in_ready_o, 1'b1);
        check("rs_result", 128'(bus.result_o), '0);
        #2;
        rst_ni = 1'b1;
        step();
        check_bit("rs_idle", bus.out_valid_o, 1'b0);
        issue("rs_after", ops_y, 1'b1, ref_op(ops_y, 1'b1));
        step();

        // Randomized traffic against the transaction scoreboard
        exp_valid = 1'b0;
        exp_res   = '0;
        for (int i = 0; i < 600; i++) begin
            logic [63:0] x0, y0, x1, y1;
            logic        iv, orr, sb, acc;
            rand_pair(x0, y0);
            rand_pair(x1, y1);
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 3) != 0);
            sb  = 1'($urandom_range(0, 1));
            bus.operands_i  = {y1, y0, x1, x0};
            bus.sub         = sb;
            bus.in_valid_i  = iv;
            bus.out_ready_i = orr;
            #1;
            check_bit("rnd_ready", bus.in_ready_o, !exp_valid || orr);
            acc = iv && (!exp_valid || orr);
            if (acc) begin
                exp_valid = 1'b1;
                exp_res   = ref_op({y1, y0, x1, x0}, sb);
            end else if (exp_valid && orr) begin
                exp_valid = 1'b0;
            end
            step();
            check_bit("rnd_valid", bus.out_valid_o, exp_valid);
            if (exp_valid) check("rnd_result", 128'(bus.result_o), exp_res);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/complex_add.md
COMPLEX_ADD -- requirements
Module: complex_add

Interface
REQ-001 The block SHALL have no parameters; every operand and result lane SHALL be a fixed 64-bit IEEE-754 binary64 value.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 operands_i  input  [3:0][63:0]  packed {b2,a2,b1,a1}: [0]=a1 (re1), [1]=b1 (im1), [2]=a2 (re2), [3]=b2 (im2).
REQ-006 sub  input  1  operation select: 0 = add, 1 = subtract.
REQ-007 in_valid_i  input  1  operands_i and sub are valid.
REQ-008 in_ready_o  output  1  block can accept an operation this cycle.
REQ-009 flush_i  input  1  synchronous discard of any held result.
REQ-010 result_o  output  [1:0][63:0]  [0] = real part, [1] = imaginary part.
REQ-011 out_valid_o  output  1  result_o holds a valid result.
REQ-012 out_ready_i  input  1  downstream accepts result_o this cycle.
REQ-013 busy_o  output  1  a result is held and not yet consumed.

Function
REQ-014 When sub=0, result[0] SHALL be a1+a2 and result[1] SHALL be b1+b2; when sub=1, they SHALL be a1-a2 and b1-b2; subtraction SHALL be implemented as addition with the sign of the second operand inverted.
REQ-015 Two identical binary64 adders (real lane, imaginary lane) SHALL operate in parallel with no interaction between lanes.
REQ-016 Each adder SHALL perform the following steps:
- unpack;
- swap so the larger magnitude is first;
- align by exponent difference, keeping guard, round and sticky bits (shifts ≥ 56 collapse into sticky);
- add or subtract the mantissas;
- normalize using a leading-zero count;
- round to nearest, ties to even.
REQ-017 Subnormal inputs SHALL be treated as signed zero, and subnormal results SHALL be flushed to zero with the computed sign.
REQ-018 Exponent overflow after rounding SHALL produce a signed infinity (exponent 0x7FF, mantissa 0).
REQ-019 Special-value rules:
- any NaN input, or inf minus inf, SHALL produce 0x7FF8000000000000;
- inf combined with a finite value SHALL produce that inf;
- an exact-zero result SHALL be +0, except that (-0)+(-0) SHALL be -0.
REQ-020 An operation SHALL be accepted when in_valid_i && in_ready_o at a rising edge; in_ready_o SHALL equal (!out_valid_o || out_ready_i).
REQ-021 Latency SHALL be 1 cycle: the result computed combinationally from the accepted inputs SHALL be registered into result_o, and out_valid_o SHALL be 1 in the following cycle.
REQ-022 A result SHALL be consumed when out_valid_o && out_ready_i.
REQ-023 If the result is consumed and there is no new acceptance in the same cycle, out_valid_o SHALL fall to 0.
REQ-024 If the result is consumed and a new operation is accepted in the same cycle, the new result SHALL replace the old one and out_valid_o SHALL stay 1 (full throughput, one result per cycle).
REQ-025 While out_valid_o=1 and out_ready_i=0, result_o and out_valid_o SHALL hold steady, and in_ready_o SHALL be 0.
REQ-026 flush_i=1 at a rising edge SHALL clear out_valid_o, SHALL block acceptance in that cycle, and SHALL take priority over all other events.
REQ-027 busy_o SHALL equal out_valid_o.
REQ-028 result_o SHALL change only on acceptance; its contents are don't-care while out_valid_o=0.

Reset
REQ-029 While rst_ni=0, out_valid_o and busy_o SHALL be 0, result_o SHALL be all zeros, and in_ready_o SHALL be 1.
REQ-030 Reset asserted while a result is held SHALL discard it immediately (asynchronously); after reset deasserts, the block SHALL be idle, and the first result SHALL appear 1 cycle after the first acceptance.

Verification
REQ-031 Basic add: sub=0; a1=0x3FF0000000000000 (1.0), b1=0x4000000000000000 (2.0), a2=0x4000000000000000 (2.0), b2=0x3FE0000000000000 (0.5).
- Required next cycle: result[0]=0x4008000000000000 (3.0), result[1]=0x4004000000000000 (2.5), out_valid_o=1.
REQ-032 Cancellation: sub=1 with both operands equal to (1.0 + j2.0).
- Required: result[0]=result[1]=0x0000000000000000 (+0).
REQ-033 Rounding ties to even: 1.0 + 0x3CA0000000000000 (2^-53) in both lanes.
- Required: 0x3FF0000000000000.
- Separately, 0x3FF0000000000001 + 2^-53 SHALL give 0x3FF0000000000002.
REQ-034 Special values:
- real lane 0x7FF0000000000000 + 0xFFF0000000000000 -> 0x7FF8000000000000;
- imaginary lane 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF -> 0x7FF0000000000000.
REQ-035 Backpressure: hold out_ready_i=0 for 3 cycles after a result appears.
- Required: result_o stable, in_ready_o=0, busy_o=1 throughout.
- Then assert out_ready_i together with a new in_valid_i: the new result SHALL appear the next cycle with out_valid_o staying 1.
REQ-036 Flush and reset while a result is held:
- flush_i=1 for one cycle -> out_valid_o=0 at the next edge;
- rst_ni=0 mid-hold -> out_valid_o=0 immediately, in_ready_o=1.
